// File: rtl/tengigeth_loop_pkg.sv
// Shared types and constants for the 10GbE loopback receive path.
package tengigeth_loop_pkg;

    typedef enum logic [1:0] {
        ST_SOF  = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } fsm_state_e;

    localparam logic [47:0] C_BCAST_MAC = 48'hFFFF_FFFF_FFFF;
    localparam logic [5:0]  C_MAC_KEEP  = 6'h3F;

    typedef struct packed {
        logic [63:0] tdata;
        logic [7:0]  tkeep;
        logic        tlast;
    } axis_beat_t;

    // Wire order puts the first MAC byte in tdata[7:0]; the MMIO register
    // holds it in [47:40]. Reorder so the two can be compared directly.
    function automatic logic [47:0] wire_to_mac(input logic [47:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24], w[39:32], w[47:40]};
    endfunction

endpackage

// File: rtl/tengigeth_axis_skid2.sv
// Two-entry registered skid buffer for AXI-Stream beats. Every output is a
// flop and in_ready does not depend combinationally on out_ready.
module tengigeth_axis_skid2
    import tengigeth_loop_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  axis_beat_t in_beat,
    input  logic       in_valid,
    output logic       in_ready,
    output axis_beat_t out_beat,
    output logic       out_valid,
    input  logic       out_ready
);

    axis_beat_t out_q, out_d;
    axis_beat_t skid_q, skid_d;
    logic       out_valid_q, out_valid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       in_ready_q, in_ready_d;
    logic       push, pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    // Refill the output register from the skid entry first, then from the
    // input; park an input beat in the skid entry when the output stalls.
    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (!out_valid_q || pop) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (push) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (push) begin
            skid_d       = in_beat;
            skid_valid_d = 1'b1;
        end
        in_ready_d = !skid_valid_d;
    end

    // Buffer state; ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_beat  = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/tengigeth_loop_addr_filter.sv
// Receive-side destination MAC filter for the loopback path. Accepted frames
// go to the loopback MUX through a registered skid buffer, rejected frames
// are consumed and discarded, and both outcomes are counted.
// Build option: ETH_LOOP_MCAST_ACCEPT_EN also accepts group-addressed frames.
//
// state | meaning
// SOF   | waiting for the first beat of a frame (idle beats are discarded)
// PASS  | forwarding the rest of an accepted frame to the buffer
// DROP  | consuming the rest of a rejected frame, always ready
module tengigeth_loop_addr_filter
    import tengigeth_loop_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             piEthCoreClk,
    input  logic             piEthCoreRst_n,
    input  logic             piFilterEn,
    input  logic [47:0]      piMacAddr,
    input  logic             piCntClr,
    input  logic [63:0]      siLY2_Data_tdata,
    input  logic [7:0]       siLY2_Data_tkeep,
    input  logic             siLY2_Data_tlast,
    input  logic             siLY2_Data_tvalid,
    output logic             siLY2_Data_tready,
    output logic [63:0]      soMUX_Data_tdata,
    output logic [7:0]       soMUX_Data_tkeep,
    output logic             soMUX_Data_tlast,
    output logic             soMUX_Data_tvalid,
    input  logic             soMUX_Data_tready,
    output logic [CNT_W-1:0] poAcceptCnt,
    output logic [CNT_W-1:0] poDropCnt
);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] accept_cnt_q, accept_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    axis_beat_t  in_beat, out_beat;
    logic        skid_in_valid, skid_in_ready;
    logic        in_ready, in_xfer;
    logic        accept_inc, drop_inc;
    logic [47:0] dst_mac;
    logic        idle_beat, runt, dst_match, dst_bcast, dst_mcast, accept;

    assign in_beat   = '{tdata: siLY2_Data_tdata, tkeep: siLY2_Data_tkeep, tlast: siLY2_Data_tlast};
    assign dst_mac   = wire_to_mac(siLY2_Data_tdata[47:0]);
    assign idle_beat = (siLY2_Data_tkeep == 8'h00) && !siLY2_Data_tlast;
    assign runt      = (siLY2_Data_tkeep[5:0] != C_MAC_KEEP) || siLY2_Data_tlast;
    assign dst_match = (dst_mac == piMacAddr);
    assign dst_bcast = (dst_mac == C_BCAST_MAC);
`ifdef ETH_LOOP_MCAST_ACCEPT_EN
    assign dst_mcast = siLY2_Data_tdata[0];
`else
    assign dst_mcast = 1'b0;
`endif
    // A runt cannot carry a full destination, so it is dropped even with the filter off.
    assign accept    = !runt && (!piFilterEn || dst_match || dst_bcast || dst_mcast);
    assign in_xfer   = siLY2_Data_tvalid & in_ready;

    // State register.
    always_ff @(posedge piEthCoreClk or negedge piEthCoreRst_n) begin
        if (!piEthCoreRst_n) begin
            state_q <= ST_SOF;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state; filter inputs only matter on the first beat.
    always_comb begin
        state_d = state_q;
        if (in_xfer) begin
            case (state_q)
                ST_SOF: begin
                    if (!idle_beat) begin
                        if (siLY2_Data_tlast) state_d = ST_SOF;
                        else                  state_d = accept ? ST_PASS : ST_DROP;
                    end
                end
                ST_PASS, ST_DROP: begin
                    if (siLY2_Data_tlast) state_d = ST_SOF;
                end
                default: state_d = ST_SOF;
            endcase
        end
    end

    // FSM outputs: ready selection, buffer write and counter strobes.
    // Ready is a mux of two flops, so it never sees soMUX tready.
    always_comb begin
        in_ready      = skid_in_ready;
        skid_in_valid = 1'b0;
        accept_inc    = 1'b0;
        drop_inc      = 1'b0;
        case (state_q)
            ST_SOF: begin
                skid_in_valid = siLY2_Data_tvalid & !idle_beat & accept;
                accept_inc    = siLY2_Data_tvalid & skid_in_ready & !idle_beat & accept;
                drop_inc      = siLY2_Data_tvalid & skid_in_ready & !idle_beat & !accept;
            end
            ST_PASS: skid_in_valid = siLY2_Data_tvalid;
            ST_DROP: in_ready = 1'b1;
            default: ;
        endcase
    end

    // Saturating counters; clear wins over a same-cycle increment.
    always_comb begin
        accept_cnt_d = accept_cnt_q;
        drop_cnt_d   = drop_cnt_q;
        if (piCntClr) begin
            accept_cnt_d = '0;
            drop_cnt_d   = '0;
        end else begin
            if (accept_inc && (accept_cnt_q != '1)) accept_cnt_d = accept_cnt_q + 1'b1;
            if (drop_inc && (drop_cnt_q != '1))     drop_cnt_d   = drop_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge piEthCoreClk or negedge piEthCoreRst_n) begin
        if (!piEthCoreRst_n) begin
            accept_cnt_q <= '0;
            drop_cnt_q   <= '0;
        end else begin
            accept_cnt_q <= accept_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    tengigeth_axis_skid2 u_skid (
        .clk       (piEthCoreClk),
        .rst_n     (piEthCoreRst_n),
        .in_beat   (in_beat),
        .in_valid  (skid_in_valid),
        .in_ready  (skid_in_ready),
        .out_beat  (out_beat),
        .out_valid (soMUX_Data_tvalid),
        .out_ready (soMUX_Data_tready)
    );

    assign siLY2_Data_tready = in_ready;
    assign soMUX_Data_tdata  = out_beat.tdata;
    assign soMUX_Data_tkeep  = out_beat.tkeep;
    assign soMUX_Data_tlast  = out_beat.tlast;
    assign poAcceptCnt       = accept_cnt_q;
    assign poDropCnt         = drop_cnt_q;

endmodule

// File: tb/tb_tengigeth_loop_addr_filter.sv
// Directed bench for the loopback destination MAC filter.
module tb_tengigeth_loop_addr_filter;

    localparam int CNT_W = 4;
    localparam logic [47:0] MY_MAC = 48'h000A_3501_0203;
    localparam logic [47:0] OTHER  = 48'h000A_3501_0204;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] MCAST  = 48'h0100_5E00_0001;

    typedef logic [72:0] beat_t;

    logic             clk = 1'b0;
    logic             rst_n, filter_en, cnt_clr;
    logic [47:0]      mac;
    logic [63:0]      in_tdata, out_tdata;
    logic [7:0]       in_tkeep, out_tkeep;
    logic             in_tlast, in_valid, in_ready;
    logic             out_tlast, out_valid, out_ready;
    logic [CNT_W-1:0] acc_cnt, drop_cnt;

    int    checks = 0;
    int    passed = 0;
    int    cyc = 0;
    int    stall_viol = 0;
    int    stall_seen = 0;
    int    first_in_cyc;
    bit    rand_rdy = 1'b0;
    bit    ready_dropped;
    logic  stall_prev = 1'b0;
    beat_t stall_beat;
    beat_t cur;
    beat_t frm[$];
    beat_t exp_q[$];
    beat_t cap_q[$];
    int    cap_cyc[$];

    always #5 clk = ~clk;

    tengigeth_loop_addr_filter #(.CNT_W(CNT_W)) dut (
        .piEthCoreClk      (clk),
        .piEthCoreRst_n    (rst_n),
        .piFilterEn        (filter_en),
        .piMacAddr         (mac),
        .piCntClr          (cnt_clr),
        .siLY2_Data_tdata  (in_tdata),
        .siLY2_Data_tkeep  (in_tkeep),
        .siLY2_Data_tlast  (in_tlast),
        .siLY2_Data_tvalid (in_valid),
        .siLY2_Data_tready (in_ready),
        .soMUX_Data_tdata  (out_tdata),
        .soMUX_Data_tkeep  (out_tkeep),
        .soMUX_Data_tlast  (out_tlast),
        .soMUX_Data_tvalid (out_valid),
        .soMUX_Data_tready (out_ready),
        .poAcceptCnt       (acc_cnt),
        .poDropCnt         (drop_cnt)
    );

    assign cur = {out_tdata, out_tkeep, out_tlast};

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: capture handshakes and record any change during a stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev <= 1'b0;
        end else begin
            if (stall_prev) begin
                stall_seen <= stall_seen + 1;
                if (!out_valid || cur != stall_beat) stall_viol <= stall_viol + 1;
            end
            if (out_valid && out_ready) begin
                cap_q.push_back(cur);
                cap_cyc.push_back(cyc);
            end
            stall_prev <= out_valid && !out_ready;
            stall_beat <= cur;
        end
    end

    function automatic logic [47:0] mac_wire(input logic [47:0] m);
        return {m[7:0], m[15:8], m[23:16], m[31:24], m[39:32], m[47:40]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic build(input logic [47:0] dst, input int n, input logic [7:0] id,
                         input logic [7:0] k0, input logic [7:0] klast);
        logic [63:0] d;
        logic [7:0]  k;
        frm.delete();
        for (int i = 0; i < n; i++) begin
            if (i == 0) d = {8'hA0, id, mac_wire(dst)};
            else        d = {id, 8'(i), 8'hC3, id, 8'(i), 8'h5A, 16'hBEEE};
            if (i == 0)          k = k0;
            else if (i == n - 1) k = klast;
            else                 k = 8'hFF;
            frm.push_back({d, k, (i == n - 1)});
        end
    endtask

    task automatic send(input int flip_at, input bit clr_first);
        int   n;
        logic r;
        ready_dropped = 1'b0;
        for (int i = 0; i < frm.size(); i++) begin
            {in_tdata, in_tkeep, in_tlast} = frm[i];
            in_valid = 1'b1;
            if (i == 0 && clr_first) cnt_clr = 1'b1;
            n = 0;
            forever begin
                @(negedge clk);
                r = in_ready;
                if (!r) ready_dropped = 1'b1;
                if (i == 0 && r) first_in_cyc = cyc;
                tick();
                if (r) break;
                n++;
                if (n > 300) begin
                    checks++;
                    $display("FAIL send_timeout: beat %0d never accepted, want accepted within 300 cycles", i);
                    in_valid = 1'b0;
                    cnt_clr  = 1'b0;
                    return;
                end
            end
            cnt_clr = 1'b0;
            if (flip_at == i) filter_en = ~filter_en;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int w = 0;
        while (cap_q.size() < exp_q.size() && w < limit) begin
            tick();
            w++;
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; filter_en = 1'b1; mac = MY_MAC; cnt_clr = 1'b0;
        in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b0) $display("FAIL rst_tready: got %b want 0", in_ready); else passed++;
        checks++; if (out_valid !== 1'b0 || out_tlast !== 1'b0) $display("FAIL rst_tvalid_tlast: got %b%b want 00", out_valid, out_tlast); else passed++;
        checks++; if (out_tdata !== 64'd0 || out_tkeep !== 8'd0) $display("FAIL rst_tdata: got %h/%h want 0/0", out_tdata, out_tkeep); else passed++;
        checks++; if (acc_cnt !== 4'd0 || drop_cnt !== 4'd0) $display("FAIL rst_cnt: got %0d/%0d want 0/0", acc_cnt, drop_cnt); else passed++;
        rst_n = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1) $display("FAIL rst_release_tready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_match();
        int errs = 0;
        cap_q.delete(); cap_cyc.delete(); exp_q.delete();
        build(MY_MAC, 8, 8'h01, 8'hFF, 8'hFF);
        foreach (frm[i]) exp_q.push_back(frm[i]);
        send(-1, 1'b0);
        drain(50);
        checks++; if (cap_q.size() !== 8) $display("FAIL match_beats: got %0d want 8", cap_q.size()); else passed++;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) errs++;
        checks++; if (errs != 0) $display("FAIL match_data: got %0d bad beats want 0", errs); else passed++;
        if (cap_cyc.size() == 8) begin
            checks++; if (cap_cyc[0] - first_in_cyc != 1) $display("FAIL match_latency: got %0d want 1", cap_cyc[0] - first_in_cyc); else passed++;
            checks++; if (cap_cyc[7] - cap_cyc[0] != 7) $display("FAIL match_throughput: got %0d cycles want 7", cap_cyc[7] - cap_cyc[0]); else passed++;
        end
        checks++; if (acc_cnt !== 4'd1 || drop_cnt !== 4'd0) $display("FAIL match_cnt: got %0d/%0d want 1/0", acc_cnt, drop_cnt); else passed++;
    endtask

    task automatic test_mismatch();
        cap_q.delete(); exp_q.delete();
        build(OTHER, 8, 8'h02, 8'hFF, 8'hFF);
        send(-1, 1'b0);
        drain(10);
        checks++; if (cap_q.size() !== 0) $display("FAIL mismatch_beats: got %0d want 0", cap_q.size()); else passed++;
        checks++; if (ready_dropped !== 1'b0) $display("FAIL mismatch_tready: got low during frame want always 1"); else passed++;
        checks++; if (acc_cnt !== 4'd1 || drop_cnt !== 4'd1) $display("FAIL mismatch_cnt: got %0d/%0d want 1/1", acc_cnt, drop_cnt); else passed++;
    endtask

    task automatic test_bcast_mcast();
        int errs = 0;
        int want_acc, want_drop, want_beats;
        cap_q.delete(); exp_q.delete();
        build(BCAST, 4, 8'h03, 8'hFF, 8'hFF);
        foreach (frm[i]) exp_q.push_back(frm[i]);
        send(-1, 1'b0);
        build(MCAST, 3, 8'h04, 8'hFF, 8'h03);
`ifdef ETH_LOOP_MCAST_ACCEPT_EN
        foreach (frm[i]) exp_q.push_back(frm[i]);
        want_acc = 3; want_drop = 1; want_beats = 7;
`else
        want_acc = 2; want_drop = 2; want_beats = 4;
`endif
        send(-1, 1'b0);
        drain(50);
        checks++; if (cap_q.size() !== want_beats) $display("FAIL bcast_mcast_beats: got %0d want %0d", cap_q.size(), want_beats); else passed++;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) errs++;
        checks++; if (errs != 0) $display("FAIL bcast_mcast_data: got %0d bad beats want 0", errs); else passed++;
        checks++; if (acc_cnt !== 4'(want_acc) || drop_cnt !== 4'(want_drop)) $display("FAIL bcast_mcast_cnt: got %0d/%0d want %0d/%0d", acc_cnt, drop_cnt, want_acc, want_drop); else passed++;
    endtask

    task automatic test_filter_off_runt();
        int errs = 0;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cap_q.delete(); exp_q.delete();
        filter_en = 1'b0;
        build(48'h1234_5678_9ABC, 5, 8'h05, 8'hFF, 8'h7F);
        foreach (frm[i]) exp_q.push_back(frm[i]);
        send(2, 1'b0);                       // filter turns back on mid-frame
        filter_en = 1'b0;
        frm.delete();
        frm.push_back({64'h0123_4567_89AB_CDEF, 8'h00, 1'b0});
        send(-1, 1'b0);                      // idle beat in SOF
        build(MY_MAC, 1, 8'h06, 8'h0F, 8'h0F);
        send(-1, 1'b0);                      // single-beat runt
        build(MY_MAC, 3, 8'h07, 8'h1F, 8'hFF);
        send(-1, 1'b0);                      // short first beat, multi-beat runt
        build(MY_MAC, 2, 8'h08, 8'hFF, 8'h01);
        foreach (frm[i]) exp_q.push_back(frm[i]);
        send(-1, 1'b0);
        drain(50);
        checks++; if (cap_q.size() !== 7) $display("FAIL filter_off_beats: got %0d want 7", cap_q.size()); else passed++;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) errs++;
        checks++; if (errs != 0) $display("FAIL filter_off_data: got %0d bad beats want 0", errs); else passed++;
        checks++; if (acc_cnt !== 4'd2 || drop_cnt !== 4'd2) $display("FAIL filter_off_cnt: got %0d/%0d want 2/2", acc_cnt, drop_cnt); else passed++;
        filter_en = 1'b1;
    endtask

    task automatic test_cnt_sat_clr();
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        checks++; if (acc_cnt !== 4'd0 || drop_cnt !== 4'd0) $display("FAIL cnt_clear: got %0d/%0d want 0/0", acc_cnt, drop_cnt); else passed++;
        for (int f = 0; f < 17; f++) begin
            build(MY_MAC, 2, 8'(f), 8'hFF, 8'hFF);
            send(-1, 1'b0);
        end
        build(OTHER, 2, 8'h40, 8'hFF, 8'hFF);
        send(-1, 1'b0);
        tick();
        checks++; if (acc_cnt !== 4'd15) $display("FAIL cnt_saturate: got %0d want 15", acc_cnt); else passed++;
        checks++; if (drop_cnt !== 4'd1) $display("FAIL cnt_drop_inc: got %0d want 1", drop_cnt); else passed++;
        build(MY_MAC, 2, 8'h41, 8'hFF, 8'hFF);
        send(-1, 1'b1);
        tick();
        checks++; if (acc_cnt !== 4'd0 || drop_cnt !== 4'd0) $display("FAIL cnt_clr_priority: got %0d/%0d want 0/0", acc_cnt, drop_cnt); else passed++;
    endtask

    task automatic test_back_to_back();
        int n_acc = 0, n_drop = 0, t, len, errs = 0, v0, s0;
        logic [47:0] d;
        logic [7:0]  k0;
        cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
        cap_q.delete(); exp_q.delete();
        v0 = stall_viol; s0 = stall_seen;
        rand_rdy = 1'b1;
        for (int f = 0; f < 100; f++) begin
            t  = $urandom_range(0, 3);
            k0 = 8'hFF;
            case (t)
                0:       begin d = MY_MAC; len = $urandom_range(2, 6); end
                1:       begin d = OTHER;  len = $urandom_range(1, 6); end
                2:       begin d = BCAST;  len = $urandom_range(2, 6); end
                default: begin d = MY_MAC; len = 1; k0 = 8'h0F; end
            endcase
            build(d, len, 8'(f), k0, 8'h3F);
            if (t == 0 || t == 2) begin
                n_acc++;
                foreach (frm[i]) exp_q.push_back(frm[i]);
            end else begin
                n_drop++;
            end
            send(-1, 1'b0);
        end
        drain(3000);
        rand_rdy = 1'b0; out_ready = 1'b1;
        repeat (4) tick();
        checks++; if (cap_q.size() !== exp_q.size()) $display("FAIL b2b_beats: got %0d want %0d", cap_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) errs++;
        checks++; if (errs != 0) $display("FAIL b2b_data: got %0d bad beats want 0", errs); else passed++;
        checks++; if (stall_viol - v0 != 0) $display("FAIL b2b_stall_stable: got %0d changes want 0", stall_viol - v0); else passed++;
        checks++; if (stall_seen - s0 == 0) $display("FAIL b2b_stalls: got 0 stalled cycles want >0"); else passed++;
        checks++; if (acc_cnt !== 4'((n_acc > 15) ? 15 : n_acc)) $display("FAIL b2b_acc_cnt: got %0d want %0d", acc_cnt, (n_acc > 15) ? 15 : n_acc); else passed++;
        checks++; if (drop_cnt !== 4'((n_drop > 15) ? 15 : n_drop)) $display("FAIL b2b_drop_cnt: got %0d want %0d", drop_cnt, (n_drop > 15) ? 15 : n_drop); else passed++;
    endtask

    task automatic test_reset_midframe();
        beat_t old[$];
        int errs = 0;
        out_ready = 1'b0;
        build(MY_MAC, 6, 8'h50, 8'hFF, 8'hFF);
        old = frm;
        {in_tdata, in_tkeep, in_tlast} = frm[0]; in_valid = 1'b1;
        tick();
        {in_tdata, in_tkeep, in_tlast} = frm[1];
        tick();
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) $display("FAIL midrst_full: got ready=%b valid=%b want 0/1", in_ready, out_valid); else passed++;
        checks++; if (cur !== old[0]) $display("FAIL midrst_head: got %h want %h", cur, old[0]); else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_tdata !== 64'd0 || out_tlast !== 1'b0 || in_ready !== 1'b0) $display("FAIL midrst_outputs: got valid=%b data=%h last=%b ready=%b want all 0", out_valid, out_tdata, out_tlast, in_ready); else passed++;
        in_valid = 1'b0;
        cap_q.delete(); exp_q.delete();
        tick(); tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        frm.delete();
        for (int i = 2; i < 6; i++) frm.push_back(old[i]);
        send(-1, 1'b0);
        build(MY_MAC, 3, 8'h51, 8'hFF, 8'h07);
        foreach (frm[i]) exp_q.push_back(frm[i]);
        send(-1, 1'b0);
        drain(50);
        checks++; if (cap_q.size() !== 3) $display("FAIL midrst_beats: got %0d want 3", cap_q.size()); else passed++;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) errs++;
        checks++; if (errs != 0) $display("FAIL midrst_data: got %0d bad beats want 0", errs); else passed++;
        checks++; if (acc_cnt !== 4'd1 || drop_cnt !== 4'd1) $display("FAIL midrst_cnt: got %0d/%0d want 1/1", acc_cnt, drop_cnt); else passed++;
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_bcast_mcast();
        test_filter_off_runt();
        test_cnt_sat_clr();
        test_back_to_back();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
